lfsr_rand_gen: RTL

Parametrised, synthesizable pseudo-random number generator that replaces the simulation-only `$urandom` generator. It uses a Galois LFSR with a loadable seed. Each `write` request returns one value uniformly drawn from `[0, RANGE-1]`, using rejection sampling for non-power-of-two ranges. The block serves as the random-stimulus/value source for the lab datapath, and `aleatorio` keeps its existing consumer-facing name.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_rand_gen_lfsr.sv | 32 +++
 rtl/lfsr_rand_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the Galois-LFSR random value generator.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } gen_state_t;

    // Default maximal-length right-shift Galois tap masks
    localparam logic [7:0]  TAPS_W8  = 8'hB8;        // x^8+x^6+x^5+x^4+1
    localparam logic [15:0] TAPS_W16 = 16'hB400;     // x^16+x^14+x^13+x^11+1
    localparam logic [31:0] TAPS_W32 = 32'h80200003; // x^32+x^22+x^2+x+1

    // One right-shift Galois step; callers zero-extend and truncate to their width
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        return (state >> 1) ^ (state[0] ? taps : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr_rand_gen_lfsr.sv
// Loadable Galois LFSR; a zero seed is replaced by DEFAULT_SEED so the
// register can never lock up in the all-zero state.
module galois_lfsr
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_W16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] stepped;

    assign stepped = WIDTH'(lfsr_next(32'(state), 32'(TAPS)));

    // Load beats step; zero seed maps to the default seed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= DEFAULT_SEED;
        else if (load)
            state <= (load_val == '0) ? DEFAULT_SEED : load_val;
        else if (step)
            state <= stepped;
    end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Random value source: one uniform draw in [0, RANGE-1] per write request,
// using rejection sampling on the low RBITS bits of a Galois LFSR.
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int                WIDTH        = 16,
    parameter logic [WIDTH-1:0]  TAPS         = TAPS_W16,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = 16'hACE1,
    parameter longint unsigned   RANGE        = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             free_run,
    input  logic             write,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] aleatorio
);

    localparam int RBITS = $clog2(RANGE);

    gen_state_t       state_q, state_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [RBITS-1:0] cand;
    logic             in_range;
    logic             lfsr_step;
    logic             accept;

    galois_lfsr #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .DEFAULT_SEED(DEFAULT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step    (lfsr_step),
        .load    (seed_load),
        .load_val(seed),
        .state   (lfsr_q)
    );

    // For power-of-two RANGE the compare is always true, so no rejects
    assign cand     = RBITS'(lfsr_q);
    assign in_range = (64'(cand) < RANGE);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, LFSR step and accept; seed_load aborts everything
    always_comb begin
        state_d   = state_q;
        lfsr_step = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (write) begin
                    lfsr_step = 1'b1;
                    state_d   = DRAW;
                end else if (free_run) begin
                    lfsr_step = 1'b1;
                end
            end
            DRAW: begin
                if (in_range) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end else begin
                    lfsr_step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (seed_load) begin
            state_d   = IDLE;
            lfsr_step = 1'b0;
            accept    = 1'b0;
        end
    end

    // Output register: value held until the next accept, valid is a pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aleatorio <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= accept;
            if (accept)
                aleatorio <= WIDTH'(cand);
        end
    end

    assign busy = (state_q == DRAW);

endmodule
